skolem_ic_sweep_ctrl: RTL and testbench

Sequencer that exhaustively checks a combinational Skolem-function candidate for the bvuge/bvlshr invertibility condition. It steps every {s,t} operand vector into the candidate and compares the candidate's 1-bit answer against an internal oracle, ((2^W-1) >> s) >= t. It reports the mismatch count and the first failing vector. It sits between the test/harness control and the candidate netlist, which is instantiated outside this block.

---
 rtl/skolem_chk_pkg.sv | 29 ++
 rtl/skolem_ic_oracle.sv | 15 +
 rtl/skolem_ic_sweep_ctrl.sv | 113 +++++++++++
 tb/tb_skolem_ic_sweep_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/skolem_chk_pkg.sv
// Shared types, defaults and the bvuge/bvlshr invertibility oracle
// used by the Skolem candidate sweep controllers.
package skolem_chk_pkg;

  localparam int unsigned W_DEF = 4;
  localparam int unsigned W_MAX = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // ((2^w-1) >> s) >= t, with s >= w shifting everything out
  function automatic logic ic_uge_lshr(
    input logic [W_MAX-1:0] s,
    input logic [W_MAX-1:0] t,
    input int unsigned      w
  );
    logic [W_MAX-1:0] ones;
    ones = {W_MAX{1'b1}} >> (W_MAX - w);
    if (32'(s) >= w) begin
      return t == '0;
    end
    return (ones >> s) >= t;
  endfunction

endpackage

// File: rtl/skolem_ic_oracle.sv
// Combinational wrapper around ic_uge_lshr so other sweep
// controllers can share the same reference oracle.
import skolem_chk_pkg::*;

module skolem_ic_oracle #(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         ok
);

  assign ok = ic_uge_lshr(W_MAX'(s), W_MAX'(t), W);

endmodule

// File: rtl/skolem_ic_sweep_ctrl.sv
// Exhaustive sweep of a Skolem candidate against the uge/lshr oracle.
// Optional SKOLEM_CHK_STOP_EN ends the sweep on the first mismatch.
import skolem_chk_pkg::*;

module skolem_ic_sweep_ctrl #(
  parameter int unsigned W = W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [2*W-1:0]  cand_vec,
  input  logic            cand_res,
  output logic [2*W:0]    mism_cnt,
  output logic            first_fail_vld,
  output logic [2*W-1:0]  first_fail_vec,
  output logic            pass
);

  localparam int unsigned VW = 2 * W;

  state_t          state;
  logic            ora;
  logic            mis;
  logic            last;
  logic            stop;
  logic            absorb;
  logic            cmp_mis;
  logic [VW-1:0]   cmp_vec;
  logic            res_vld;

  skolem_ic_oracle #(
    .W (W)
  ) u_oracle (
    .s  (cand_vec[VW-1:W]),
    .t  (cand_vec[W-1:0]),
    .ok (ora)
  );

  assign mis  = cand_res ^ ora;
  assign last = &cand_vec;
  assign busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  // Only compares belonging to an active sweep reach the counters
  assign absorb = cmp_mis && busy;

`ifdef SKOLEM_CHK_STOP_EN
  assign stop = cmp_mis;
`else
  assign stop = 1'b0;
`endif

  assign pass = (done || res_vld) && (mism_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cand_vec       <= '0;
      cmp_mis        <= 1'b0;
      cmp_vec        <= '0;
      mism_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      res_vld        <= 1'b0;
    end else begin
      cmp_mis <= (state == ST_RUN) && mis;
      cmp_vec <= cand_vec;

      if (absorb) begin
        mism_cnt <= mism_cnt + 1'b1;
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_vec <= cmp_vec;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_RUN;
            cand_vec       <= '0;
            mism_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            res_vld        <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_DONE;
          end else if (last) begin
            state <= ST_DRAIN;
          end else begin
            cand_vec <= cand_vec + 1'b1;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          res_vld <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_ic_sweep_ctrl.sv
// Scoreboard bench for skolem_ic_sweep_ctrl (W=4) with oracle,
// constant-0 and constant-1 candidates, reset and start handling.
module tb_skolem_ic_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] cand_vec;
  logic       cand_res;
  logic [8:0] mism_cnt;
  logic       first_fail_vld;
  logic [7:0] first_fail_vec;
  logic       pass;

  int mode = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int cnt;
    int vld;
    int vec;
    int pas;
    int lat;
  } exp_t;

  exp_t sb[$];

  skolem_ic_sweep_ctrl #(.W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .cand_vec       (cand_vec),
    .cand_res       (cand_res),
    .mism_cnt       (mism_cnt),
    .first_fail_vld (first_fail_vld),
    .first_fail_vec (first_fail_vec),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ref_or(input int v);
    int s;
    int t;
    int lim;
    s = (v >> 4) & 15;
    t = v & 15;
    lim = (s >= 4) ? 0 : (15 >> s);
    return lim >= t;
  endfunction

  always_comb begin
    cand_res = 1'b0;
    case (mode)
      0:       cand_res = ref_or(int'(cand_vec));
      1:       cand_res = 1'b0;
      default: cand_res = 1'b1;
    endcase
  end

  function automatic exp_t model(input int m);
    exp_t e;
    logic c;
    logic o;
    e = '{cnt: 0, vld: 0, vec: 0, pas: 0, lat: 258};
    for (int v = 0; v < 256; v++) begin
      o = ref_or(v);
      c = (m == 0) ? o : (m == 2);
      if (c != o) begin
        e.cnt++;
        if (e.vld == 0) begin
          e.vld = 1;
          e.vec = v;
        end
      end
    end
`ifdef SKOLEM_CHK_STOP_EN
    if (e.cnt > 0) begin
      e.cnt = 1;
      e.lat = e.vec + 3;
    end
`endif
    e.pas = (e.cnt == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input int unsigned got,
                     input int unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic launch(input int m, input bit hold, output int c0);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    sb.push_back(model(m));
    @(posedge clk);
    #1;
    c0 = cyc;
    if (!hold) start = 1'b0;
  endtask

  // ev: 0 plain, 1 start pulses at 50/258, 2 reset at cycle 100
  task automatic wait_done(input int c0, input int ev);
    int n;
    bit hit;
    exp_t e;
    hit = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n = cyc - c0 + 1;
      if (n == 1) begin
        chk("run_busy", busy, 1);
        chk("run_vec0", cand_vec, 0);
      end
      if (ev == 1) start = (n == 50 || n == 258);
      if (ev == 2 && n == 100) rst = 1'b1;
      if (ev == 2 && n == 101) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec", cand_vec, 0);
        chk("rst_cnt", mism_cnt, 0);
        chk("rst_ffvld", first_fail_vld, 0);
        chk("rst_ffvec", first_fail_vec, 0);
        chk("rst_pass", pass, 0);
        rst = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        return;
      end
      if (done) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      chk("done_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("mism_cnt", mism_cnt, e.cnt);
    chk("ff_vld", first_fail_vld, e.vld);
    chk("ff_vec", first_fail_vec, e.vec);
    chk("pass", pass, e.pas);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_vec", cand_vec, 0);
    chk("init_cnt", mism_cnt, 0);
    chk("init_ffvld", first_fail_vld, 0);
    chk("init_ffvec", first_fail_vec, 0);
    chk("init_pass", pass, 0);
    rst = 1'b0;

    launch(0, 0, c0);
    wait_done(c0, 0);
    @(negedge clk);
    chk("hold_pass", pass, 1);
    chk("hold_done", done, 0);
    chk("hold_busy", busy, 0);

    launch(1, 0, c0);
    wait_done(c0, 0);
    @(negedge clk);
    chk("hold_cnt0", mism_cnt, sb.size() == 0 ? model(1).cnt : 0);

    launch(2, 0, c0);
    wait_done(c0, 0);

    launch(0, 0, c0);
    wait_done(c0, 2);
    launch(0, 0, c0);
    wait_done(c0, 0);

    launch(0, 0, c0);
    wait_done(c0, 1);
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy0", busy, 0);
    @(negedge clk);
    chk("ign_busy1", busy, 0);

    launch(0, 1, c0);
    wait_done(c0, 0);
    sb.push_back(model(0));
    @(negedge clk);
    chk("gap_idle", busy, 0);
    @(posedge clk);
    #1;
    c0 = cyc;
    start = 1'b0;
    wait_done(c0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
